// File: rtl/uart_tx_controller.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_controller
// Description : UART transmit frame sequencer. A one-deep holding register
//               feeds an FSM that steps through the start, data, optional
//               parity and stop bits, one state cycle per bit time. It drives
//               the serializer enable and the line mux select, computes the
//               parity bit, and aborts a frame when the serializer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_controller #(
    parameter int DATA_WIDTH  = 8,
    parameter int STOP_BITS   = 1,
    parameter int SER_TIMEOUT = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    input  logic                  Ser_Done,
    output logic                  Tx_Ready,
    output logic                  Ser_En,
    output logic [DATA_WIDTH-1:0] Ser_Data,
    output logic [1:0]            Mux_Sel,
    output logic                  Par_Bit,
    output logic                  Busy,
    output logic                  Frame_Err
);

    // Line mux encodings
    localparam logic [1:0] c_MUX_START = 2'b00;
    localparam logic [1:0] c_MUX_IDLE  = 2'b01;
    localparam logic [1:0] c_MUX_DATA  = 2'b10;
    localparam logic [1:0] c_MUX_PAR   = 2'b11;

    // Counter widths and terminal values
    localparam int             c_TO_W      = $clog2(SER_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(SER_TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE    = c_TO_W'(1);
    localparam logic [1:0]     c_STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_ser_data;
    logic                  r_par_bit;
    logic                  r_frm_par_en;
    logic                  r_frm_par_typ;
    logic                  r_ser_en;
    logic [1:0]            r_mux_sel;
    logic                  r_busy;
    logic                  r_frame_err;
    logic [c_TO_W-1:0]     r_data_cnt;
    logic [1:0]            r_stop_cnt;

    logic w_accept;
    logic w_stop_last;
    logic w_load;

    // Accept only into an empty holding register; a load happens whenever the
    // FSM is about to enter START, which it does only with data waiting.
    assign w_accept    = Data_Valid & ~r_hold_full;
    assign w_stop_last = (r_state == S_STOP) && (r_stop_cnt == c_STOP_LAST);
    assign w_load      = r_hold_full && ((r_state == S_IDLE) || w_stop_last);

    assign Tx_Ready  = ~r_hold_full;
    assign Ser_En    = r_ser_en;
    assign Ser_Data  = r_ser_data;
    assign Mux_Sel   = r_mux_sel;
    assign Par_Bit   = r_par_bit;
    assign Busy      = r_busy;
    assign Frame_Err = r_frame_err;

    // Holding register: a fresh accept wins over the load-time clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= P_DATA;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Frame registers: snapshot data and parity settings at frame load
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ser_data    <= '0;
            r_par_bit     <= 1'b0;
            r_frm_par_en  <= 1'b0;
            r_frm_par_typ <= 1'b0;
        end else if (w_load) begin
            r_ser_data    <= r_hold;
            r_par_bit     <= (^r_hold) ^ Par_Typ;
            r_frm_par_en  <= Par_En;
            r_frm_par_typ <= Par_Typ;
        end
    end

    // Frame FSM; outputs are registered with the value for the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_ser_en    <= 1'b0;
            r_mux_sel   <= c_MUX_IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_data_cnt  <= '0;
            r_stop_cnt  <= '0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state   <= S_START;
                        r_mux_sel <= c_MUX_START;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    r_state    <= S_DATA;
                    r_mux_sel  <= c_MUX_DATA;
                    r_ser_en   <= 1'b1;
                    r_data_cnt <= '0;
                end
                S_DATA: begin
                    // Ser_Done has priority, so a completion on the final
                    // allowed cycle is still a good frame.
                    if (Ser_Done) begin
                        r_ser_en <= 1'b0;
                        if (r_frm_par_en) begin
                            r_state   <= S_PARITY;
                            r_mux_sel <= c_MUX_PAR;
                        end else begin
                            r_state    <= S_STOP;
                            r_mux_sel  <= c_MUX_IDLE;
                            r_stop_cnt <= '0;
                        end
                    end else if (r_data_cnt == c_TO_LAST) begin
                        r_frame_err <= 1'b1;
                        r_ser_en    <= 1'b0;
                        r_state     <= S_STOP;
                        r_mux_sel   <= c_MUX_IDLE;
                        r_stop_cnt  <= '0;
                    end else begin
                        r_data_cnt <= r_data_cnt + c_TO_ONE;
                    end
                end
                S_PARITY: begin
                    r_state    <= S_STOP;
                    r_mux_sel  <= c_MUX_IDLE;
                    r_stop_cnt <= '0;
                end
                S_STOP: begin
                    if (w_stop_last) begin
                        if (r_hold_full) begin
                            r_state   <= S_START;
                            r_mux_sel <= c_MUX_START;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_ser_en  <= 1'b0;
                    r_mux_sel <= c_MUX_IDLE;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_controller
// Description : Directed self-checking bench for uart_tx_controller. Two
//               instances (one and two stop bits) share stimulus; the idle one
//               is held in reset. Expected frame contents are queued at accept
//               time and popped when the frame reaches its first data bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_controller;

    typedef struct {
        logic [7:0] d;
        logic       pb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst1;
    logic       rst2;
    logic [7:0] p_data;
    logic       dv;
    logic       par_en;
    logic       par_typ;
    logic       ser_done;
    logic       sel;

    logic       o1_rdy, o1_en, o1_pb, o1_busy, o1_ferr;
    logic [7:0] o1_data;
    logic [1:0] o1_mux;
    logic       o2_rdy, o2_en, o2_pb, o2_busy, o2_ferr;
    logic [7:0] o2_data;
    logic [1:0] o2_mux;

    logic       w_rdy, w_en, w_pb, w_busy, w_ferr;
    logic [7:0] w_data;
    logic [1:0] w_mux;

    int   tests;
    int   fails;
    exp_t sb[$];

    uart_tx_controller #(.DATA_WIDTH(8), .STOP_BITS(1), .SER_TIMEOUT(12)) u_dut1 (
        .CLK(clk), .RST(rst1), .P_DATA(p_data), .Data_Valid(dv), .Par_En(par_en),
        .Par_Typ(par_typ), .Ser_Done(ser_done), .Tx_Ready(o1_rdy), .Ser_En(o1_en),
        .Ser_Data(o1_data), .Mux_Sel(o1_mux), .Par_Bit(o1_pb), .Busy(o1_busy),
        .Frame_Err(o1_ferr)
    );

    uart_tx_controller #(.DATA_WIDTH(8), .STOP_BITS(2), .SER_TIMEOUT(12)) u_dut2 (
        .CLK(clk), .RST(rst2), .P_DATA(p_data), .Data_Valid(dv), .Par_En(par_en),
        .Par_Typ(par_typ), .Ser_Done(ser_done), .Tx_Ready(o2_rdy), .Ser_En(o2_en),
        .Ser_Data(o2_data), .Mux_Sel(o2_mux), .Par_Bit(o2_pb), .Busy(o2_busy),
        .Frame_Err(o2_ferr)
    );

    assign w_rdy  = sel ? o2_rdy  : o1_rdy;
    assign w_en   = sel ? o2_en   : o1_en;
    assign w_pb   = sel ? o2_pb   : o1_pb;
    assign w_busy = sel ? o2_busy : o1_busy;
    assign w_ferr = sel ? o2_ferr : o1_ferr;
    assign w_data = sel ? o2_data : o1_data;
    assign w_mux  = sel ? o2_mux  : o1_mux;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference parity: count ones; even parity bit makes the total even
    function automatic logic ref_par(input logic [7:0] d, input logic typ);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return logic'(ones % 2) ^ typ;
    endfunction

    task automatic send(input logic [7:0] d);
        exp_t e;
        e.d    = d;
        e.pb   = ref_par(d, par_typ);
        p_data = d;
        dv     = 1'b1;
        sb.push_back(e);
        tick();
        dv = 1'b0;
    endtask

    // Wait (bounded) for the first data bit, then score the frame contents
    task automatic wait_data(input string tag);
        exp_t e;
        int   n = 0;
        while (w_en !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_reach_data"}, 32'(w_en), 32'd1);
        chk({tag, "_data_mux"}, 32'(w_mux), 32'd2);
        chk({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_ser_data"}, 32'(w_data), 32'(e.d));
            chk({tag, "_par_bit"}, 32'(w_pb), 32'(e.pb));
        end
    endtask

    // Full frame: Ser_Done on the n_data-th data cycle; parity inputs are
    // flipped mid-frame to show the frame uses its own sampled copies.
    task automatic run_frame(input logic [7:0] d, input int n_data, input logic exp_par,
                             input logic exp_pb, input int n_stop, input string tag);
        logic sv_en, sv_typ;
        send(d);
        wait_data(tag);
        sv_en   = par_en;
        sv_typ  = par_typ;
        par_en  = ~par_en;
        par_typ = ~par_typ;
        for (int i = 1; i < n_data; i++) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk({tag, "_no_ferr"}, 32'(w_ferr), 32'd0);
        chk({tag, "_en_drop"}, 32'(w_en), 32'd0);
        if (exp_par) begin
            chk({tag, "_parity_mux"}, 32'(w_mux), 32'd3);
            chk({tag, "_parity_bit"}, 32'(w_pb), 32'(exp_pb));
            tick();
        end
        for (int s = 0; s < n_stop; s++) begin
            chk({tag, "_stop_mux"}, 32'(w_mux), 32'd1);
            chk({tag, "_stop_busy"}, 32'(w_busy), 32'd1);
            tick();
        end
        chk({tag, "_idle_busy"}, 32'(w_busy), 32'd0);
        chk({tag, "_idle_mux"}, 32'(w_mux), 32'd1);
        par_en  = sv_en;
        par_typ = sv_typ;
    endtask

    initial begin
        int busy_cnt;
        tests    = 0;
        fails    = 0;
        rst1     = 1'b0;
        rst2     = 1'b1;
        dv       = 1'b0;
        p_data   = 8'h00;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        ser_done = 1'b0;
        sel      = 1'b0;

        // Asynchronous reset asserted mid-cycle, checked before any edge
        #12;
        rst1 = 1'b1;
        #1;
        chk("rst_mux", 32'(o1_mux), 32'd1);
        chk("rst_ready", 32'(o1_rdy), 32'd1);
        chk("rst_busy", 32'(o1_busy), 32'd0);
        chk("rst_ser_en", 32'(o1_en), 32'd0);
        chk("rst_ferr", 32'(o1_ferr), 32'd0);
        tick();
        rst1 = 1'b0;
        tick();
        chk("idle_busy", 32'(o1_busy), 32'd0);

        // Single byte 0xA5, exact cycle timeline
        send(8'hA5);
        chk("a5_c0_busy", 32'(o1_busy), 32'd0);
        chk("a5_c0_ready", 32'(o1_rdy), 32'd0);
        tick();
        chk("a5_c1_mux", 32'(o1_mux), 32'd0);
        chk("a5_c1_busy", 32'(o1_busy), 32'd1);
        chk("a5_c1_en", 32'(o1_en), 32'd0);
        tick();
        wait_data("a5");
        for (int k = 3; k <= 11; k++) begin
            tick();
            chk("a5_data_en", 32'(o1_en), 32'd1);
        end
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("a5_c12_mux", 32'(o1_mux), 32'd1);
        chk("a5_c12_busy", 32'(o1_busy), 32'd1);
        chk("a5_c12_en", 32'(o1_en), 32'd0);
        tick();
        chk("a5_c13_busy", 32'(o1_busy), 32'd0);
        chk("a5_c13_ready", 32'(o1_rdy), 32'd1);

        // Parity variants
        par_en  = 1'b1;
        par_typ = 1'b0;
        run_frame(8'h07, 3, 1'b1, 1'b1, 1, "p07_even");
        par_typ = 1'b1;
        run_frame(8'h07, 2, 1'b1, 1'b0, 1, "p07_odd");
        par_typ = 1'b0;
        run_frame(8'h00, 1, 1'b1, 1'b0, 1, "p00_even");
        // Ser_Done on exactly the last allowed data cycle is a normal frame
        run_frame(8'h3C, 12, 1'b1, 1'b0, 1, "edge12");

        // Back-to-back with an ignored third byte
        par_en = 1'b0;
        send(8'h11);
        wait_data("b2b_1");
        send(8'h22);
        chk("b2b_ready_full", 32'(o1_rdy), 32'd0);
        p_data = 8'h33;
        dv     = 1'b1;
        tick();
        dv = 1'b0;
        chk("b2b_ready_still", 32'(o1_rdy), 32'd0);
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        chk("b2b_stop_mux", 32'(o1_mux), 32'd1);
        tick();
        chk("b2b_restart_mux", 32'(o1_mux), 32'd0);
        chk("b2b_restart_busy", 32'(o1_busy), 32'd1);
        chk("b2b_ready_freed", 32'(o1_rdy), 32'd1);
        tick();
        wait_data("b2b_2");
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        tick();
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (o1_busy !== 1'b0) busy_cnt++;
            tick();
        end
        chk("b2b_no_third", busy_cnt, 0);
        chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

        // Serializer timeout with parity enabled
        par_en = 1'b1;
        send(8'h5A);
        wait_data("to");
        for (int k = 1; k <= 12; k++) begin
            chk("to_data_en", 32'(o1_en), 32'd1);
            chk("to_no_early_ferr", 32'(o1_ferr), 32'd0);
            tick();
        end
        chk("to_ferr_pulse", 32'(o1_ferr), 32'd1);
        chk("to_stop_mux", 32'(o1_mux), 32'd1);
        chk("to_en_drop", 32'(o1_en), 32'd0);
        chk("to_busy", 32'(o1_busy), 32'd1);
        tick();
        chk("to_ferr_clear", 32'(o1_ferr), 32'd0);
        chk("to_idle", 32'(o1_busy), 32'd0);

        // Two stop bits on the second instance
        rst1   = 1'b1;
        sel    = 1'b1;
        rst2   = 1'b0;
        par_en = 1'b0;
        tick();
        run_frame(8'hC3, 4, 1'b0, 1'b0, 2, "stop2");

        // Reset during DATA with a byte held
        send(8'h81);
        wait_data("rstdata");
        send(8'h42);
        chk("rstdata_full", 32'(o2_rdy), 32'd0);
        #3;
        rst2 = 1'b1;
        #1;
        chk("rstdata_mux", 32'(o2_mux), 32'd1);
        chk("rstdata_busy", 32'(o2_busy), 32'd0);
        chk("rstdata_ready", 32'(o2_rdy), 32'd1);
        chk("rstdata_en", 32'(o2_en), 32'd0);
        sb.delete();
        tick();
        rst2 = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (o2_busy !== 1'b0) busy_cnt++;
        end
        chk("rstdata_no_frame", busy_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
Frame sequencer for the UART transmitter. It accepts bytes through a one-deep holding register and steps an FSM through start, data, optional parity and stop bits. It drives the serializer enable and the Tx output-mux select, and computes the parity bit. It runs on the baud-rate clock, so one state cycle equals one bit time. It sits between the bus-side Tx register and the UART_Tx serializer/mux datapath.

Parameters:
DATA_WIDTH, 8, width of P_DATA / Ser_Data
STOP_BITS, 1, number of stop-bit cycles (legal: 1 or 2)
SER_TIMEOUT, 12, max DATA-state cycles without Ser_Done before abort

Ports:
CLK  input  1  baud-rate clock, rising edge
RST  input  1  asynchronous reset, active-high
P_DATA  input  DATA_WIDTH  byte to transmit
Data_Valid  input  1  P_DATA valid; accepted when Tx_Ready=1
Par_En  input  1  1 = append parity bit
Par_Typ  input  1  0 = even parity, 1 = odd parity
Ser_Done  input  1  serializer has shifted all bits
Tx_Ready  output  1  holding register empty, can accept
Ser_En  output  1  serializer enable
Ser_Data  output  DATA_WIDTH  frame data presented to serializer
Mux_Sel  output  2  00 start(0), 01 stop/idle(1), 10 serial data, 11 parity
Par_Bit  output  1  parity of the current frame
Busy  output  1  frame in progress
Frame_Err  output  1  one-cycle pulse on serializer timeout

Behaviour:
- Reset (RST=1, async): state=IDLE; Hold_Full=0; Ser_Data=0; Par_Bit=0; frame Par_En/Par_Typ=0; Ser_En=0; Mux_Sel=01; Busy=0; Tx_Ready=1; Frame_Err=0; all counters=0.
- Reset mid-frame aborts immediately. The line returns to 1 (Mux_Sel=01). Held data is discarded.
- Holding register:
  - Accept = Data_Valid & Tx_Ready. The accept captures P_DATA and sets Hold_Full on the edge.
  - Tx_Ready = !Hold_Full.
  - Data_Valid while Tx_Ready=0 is ignored. It is not queued and no error is flagged.
- Frame load occurs on the transition IDLE->START or STOP->START:
  - Ser_Data <= Hold.
  - Hold_Full cleared.
  - Par_En and Par_Typ sampled into frame registers.
  - Par_Bit <= (^Hold) ^ Par_Typ.
  - If an accept coincides with a load, Hold takes the new P_DATA and Hold_Full stays 1.
- Input changes to Par_En/Par_Typ mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Mux_Sel=01, Busy=0. Goes to START when Hold_Full=1.
  - START: one cycle, Mux_Sel=00, Busy=1. Always goes to DATA.
  - DATA: Ser_En=1, Mux_Sel=10.
    - On sampled Ser_Done=1: go to PARITY if frame Par_En=1, else STOP.
    - Ser_En is 0 in the cycle after Ser_Done is seen.
  - PARITY: one cycle, Mux_Sel=11. Goes to STOP.
  - STOP: Mux_Sel=01. Lasts STOP_BITS cycles, counted by the stop counter.
    - On the last stop cycle: go to START if Hold_Full=1 (back-to-back, no idle gap), else IDLE.
- Ser_En and Mux_Sel are decoded from the state register only, with no input-to-output combinational paths. Busy=1 in every state except IDLE.
- Latency: accept edge at cycle 0, START at cycle 1, first DATA cycle at cycle 2.
- Timeout:
  - The DATA cycle counter resets on DATA entry.
  - If it reaches SER_TIMEOUT with Ser_Done still 0: Frame_Err pulses for 1 cycle, Ser_En drops, the parity bit is skipped, and the FSM goes to STOP.
  - Ser_Done on exactly the SER_TIMEOUT-th cycle counts as a normal completion.
- Ser_Done outside DATA is ignored.

Test Plan:
- Reset then idle:
  - Stimulus: assert RST mid-cycle.
  - Required: Mux_Sel=01, Tx_Ready=1, Busy=0, Ser_En=0 immediately, without waiting for a clock.
- Single byte 0xA5, Par_En=0, STOP_BITS=1, bench asserts Ser_Done on the 10th Ser_En cycle:
  - Required: START at cycle 1, DATA cycles 2-11, STOP cycle 12, IDLE cycle 13.
  - Ser_Data=0xA5; Busy high for cycles 1-12.
- Parity:
  - 0x07 with Par_En=1, Par_Typ=0 -> PARITY state with Par_Bit=1.
  - 0x07 with Par_Typ=1 -> Par_Bit=0.
  - 0x00 even -> Par_Bit=0.
- Back-to-back:
  - Stimulus: send 0x11, then 0x22 during DATA of the first frame.
  - Required: Tx_Ready=0 after the second accept; a third Data_Valid (0x33) is ignored.
  - Required: STOP goes straight to START; Ser_Data=0x22; 0x33 is never transmitted.
- Timeout (SER_TIMEOUT=12):
  - Stimulus: Ser_Done held 0.
  - Required: Frame_Err pulses once after 12 DATA cycles, then STOP, then IDLE; no PARITY state even with Par_En=1.
- STOP_BITS=2, plus reset in DATA:
  - STOP lasts exactly 2 cycles.
  - RST asserted in DATA with Hold_Full=1 -> IDLE, Tx_Ready=1, and no frame after reset release.
